// File: rtl/div_hilo_unit.sv
// Multi-cycle restoring radix-2 divider producing the MIPS HI (remainder) / LO (quotient) pair.
// Signed divides run on magnitudes, and the result signs are fixed up on entry to DONE.
module div_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             wediv,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               dvd_neg, dvs_neg;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;

  assign accept  = (state_q == S_IDLE) && start && !annul;
  assign dvd_neg = signed_div && dividend[WIDTH-1];
  assign dvs_neg = signed_div && divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  // The shifted remainder needs WIDTH+1 bits; bit WIDTH of the difference is the borrow.
  assign trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign rem_nxt = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rem_d   = '0;
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          qsign_d = dvd_neg ^ dvs_neg;
          rsign_d = dvd_neg;
          cnt_d   = '0;
          if (divisor == '0) begin
            // Divide by zero is a defined result, not a trap.
            state_d = S_DONE;
            hi_d    = dividend;
            lo_d    = '1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_DONE;
            lo_d    = qsign_q ? -quo_nxt : quo_nxt;
            hi_d    = rsign_q ? -rem_nxt : rem_nxt;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Combinational so the stall reaches the pipeline in the issue cycle.
  assign busy   = rst_n && (accept || (state_q == S_CALC));
  assign wediv  = (state_q == S_DONE);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Bench for div_hilo_unit: expected HI/LO pairs are queued at issue and checked on each wediv.
module tb_div_hilo_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic         annul = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, wediv;
  logic [W-1:0] hi_out, lo_out;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res = '0;
  int n_vec = 0;
  int n_bad = 0;

  div_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_div(signed_div), .annul(annul),
    .dividend(dividend), .divisor(divisor), .busy(busy), .wediv(wediv),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input string name);
    int lat, seen, hs_bad;
    logic [2*W-1:0] exp;
    lat = (b == '0) ? 1 : W + 1;
    @(posedge clk); #1;
    dividend = a; divisor = b; signed_div = sg; start = 1'b1;
    exp_q.push_back({ehi, elo});
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL %s busy_issue got=%b want=1", name, busy);
    end
    seen = -1; hs_bad = 0;
    for (int c = 1; c <= W + 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (wediv === 1'b1 && seen < 0) begin
        seen = c;
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          n_vec++;
          if ({hi_out, lo_out} !== exp) begin
            n_bad++;
            $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h", name, hi_out, lo_out,
                     exp[2*W-1:W], exp[W-1:0]);
          end
        end
      end else if (wediv !== 1'b0) begin
        hs_bad++;
      end
      if (busy !== ((c < lat) ? 1'b1 : 1'b0)) hs_bad++;
    end
    n_vec++;
    if (seen != lat) begin
      n_bad++; $display("FAIL %s latency got=%0d want=%0d", name, seen, lat);
    end
    n_vec++;
    if (hs_bad != 0) begin
      n_bad++; $display("FAIL %s busy_wediv_profile errors=%0d want=0", name, hs_bad);
    end
    exp_q.delete();
    last_res = {ehi, elo};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    #2;
    n_vec++;
    if ({busy, wediv, hi_out, lo_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b wediv=%b hi=%h lo=%h want all 0", busy, wediv, hi_out, lo_out);
    end
    #10;
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    run_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, "udiv_100_7");
  endtask

  task automatic test_signed();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "sdiv_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, "sdiv_7_m2");
  endtask

  task automatic test_boundaries();
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF, "udiv_max_1");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, "sdiv_overflow");
    run_div(32'd5, 32'd9, 1'b0, 32'd5, 32'd0, "udiv_5_9");
  endtask

  task automatic test_div_zero();
    run_div(32'h1234, 32'd0, 1'b0, 32'h1234, 32'hFFFF_FFFF, "udiv_by_zero");
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "sdiv_by_zero");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic signed [W-1:0] sa, sb;
    logic sg;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == '0) b = 32'd1;
      sg = (i % 2) == 1;
      if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      sa = a; sb = b;
      if (sg) run_div(a, b, sg, W'(sa % sb), W'(sa / sb), "rand_signed");
      else    run_div(a, b, sg, a % b, a / b, "rand_unsigned");
    end
  endtask

  task automatic test_annul();
    int bad;
    run_div(32'd50, 32'd3, 1'b0, 32'd2, 32'd16, "annul_prior");
    @(posedge clk); #1;
    dividend = 32'hFFFF; divisor = 32'd3; signed_div = 1'b0; start = 1'b1;
    bad = 0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 10) annul = 1'b1;
      if (c == 11) annul = 1'b0;
      if (wediv !== 1'b0) bad++;
    end
    #1;
    n_vec++;
    if (busy !== 1'b0 || bad != 0) begin
      n_bad++; $display("FAIL annul_to_idle busy=%b strobes=%0d want busy=0 strobes=0", busy, bad);
    end
    n_vec++;
    if ({hi_out, lo_out} !== last_res) begin
      n_bad++; $display("FAIL annul_hold got=%h want=%h", {hi_out, lo_out}, last_res);
    end
    run_div(32'd9, 32'd4, 1'b0, 32'd1, 32'd2, "after_annul");
  endtask

  task automatic test_reset_mid();
    int bad;
    @(posedge clk); #1;
    dividend = 32'd1000; divisor = 32'd3; signed_div = 1'b0; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, wediv, hi_out, lo_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid got busy=%b wediv=%b hi=%h lo=%h want all 0", busy, wediv, hi_out, lo_out);
    end
    #3;
    rst_n = 1'b1;
    last_res = '0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (wediv !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_bad++; $display("FAIL reset_mid_quiet errors=%0d want=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int w0, w1, nw, b34;
    logic [2*W-1:0] exp;
    @(posedge clk); #1;
    dividend = 32'd1000; divisor = 32'd10; signed_div = 1'b0; start = 1'b1;
    exp_q.push_back({32'd0, 32'd100});
    exp_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
    w0 = -1; w1 = -1; nw = 0; b34 = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == 34) b34 = int'(busy);
      if (wediv === 1'b1) begin
        if (nw == 0) w0 = c; else if (nw == 1) w1 = c;
        nw++;
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          n_vec++;
          if ({hi_out, lo_out} !== exp) begin
            n_bad++; $display("FAIL b2b_result%0d got=%h want=%h", nw, {hi_out, lo_out}, exp);
          end
        end
        if (nw == 1) begin
          dividend = 32'hFFFF_FF9C; divisor = 32'd7; signed_div = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (w0 != 33 || w1 != 67 || nw != 2) begin
      n_bad++; $display("FAIL b2b_timing got w0=%0d w1=%0d n=%0d want 33 67 2", w0, w1, nw);
    end
    n_vec++;
    if (b34 != 1) begin
      n_bad++; $display("FAIL b2b_accept_busy got=%0d want=1", b34);
    end
    exp_q.delete();
    last_res = {32'hFFFF_FFFE, 32'hFFFF_FFF2};
  endtask

  task automatic test_start_annul();
    int bad;
    @(posedge clk); #1;
    dividend = 32'd20; divisor = 32'd3; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL start_annul_busy got=%b want=0", busy);
    end
    bad = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0; annul = 1'b0;
      #1;
      if (busy !== 1'b0 || wediv !== 1'b0 || {hi_out, lo_out} !== last_res) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_bad++; $display("FAIL start_annul_no_accept errors=%0d want=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_boundaries();
    test_div_zero();
    test_random();
    test_annul();
    test_reset_mid();
    test_unsigned();
    test_back_to_back();
    test_start_annul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
